// File: rtl/io_map_pkg.sv
// io_map_pkg: address map and shared types for the I/O bridge.
//   - Device windows (timer, switches, display) and the bridge status
//     register addresses.
//   - target_e: which device an address selects.
//   - wbuf_t: the one-entry posted-write buffer.
package io_map_pkg;

    localparam logic [31:0] TMR_BASE     = 32'h0000_7f00;
    localparam logic [31:0] TMR_LIMIT    = 32'h0000_7f0b;
    localparam logic [31:0] SW_BASE      = 32'h0000_7f2c;
    localparam logic [31:0] SW_LIMIT     = 32'h0000_7f33;
    localparam logic [31:0] DGT_ADDR0    = 32'h0000_7f38;
    localparam logic [31:0] DGT_ADDR1    = 32'h0000_7f3c;
    localparam logic [31:0] STAT_ERR     = 32'h0000_7f40;
    localparam logic [31:0] STAT_BADADDR = 32'h0000_7f44;

    typedef enum logic [2:0] {
        TGT_NONE = 3'd0,
        TGT_TMR  = 3'd1,
        TGT_SW   = 3'd2,
        TGT_DGT  = 3'd3,
        TGT_STAT = 3'd4
    } target_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        target_e     target;
    } wbuf_t;

endpackage

// File: rtl/io_addr_decode.sv
// io_addr_decode: combinational CPU address decode.
// Ports:
//   addr     in  32  CPU byte address
//   target   out     selected device (TGT_NONE when unmapped/misaligned)
//   writable out  1  target accepts stores at this address
// Macro IO_BRIDGE_ERR_EN maps the bridge status registers.
module io_addr_decode
    import io_map_pkg::*;
(
    input  logic [31:0] addr,
    output target_e     target,
    output logic        writable
);

    always_comb begin
        target   = TGT_NONE;
        writable = 1'b0;
        // Only word-aligned accesses decode to anything.
        if (addr[1:0] == 2'b00) begin
            if (addr >= TMR_BASE && addr <= TMR_LIMIT) begin
                target   = TGT_TMR;
                writable = 1'b1;
            end else if (addr >= SW_BASE && addr <= SW_LIMIT) begin
                target   = TGT_SW;
            end else if (addr == DGT_ADDR0 || addr == DGT_ADDR1) begin
                target   = TGT_DGT;
                writable = 1'b1;
`ifdef IO_BRIDGE_ERR_EN
            end else if (addr == STAT_ERR) begin
                target   = TGT_STAT;
                writable = 1'b1;
            end else if (addr == STAT_BADADDR) begin
                // BADADDR is read-only; a store to it is a bus error.
                target   = TGT_STAT;
`endif
            end
        end
    end

endmodule

// File: rtl/io_bridge.sv
// io_bridge: MIPS data-memory port to memory-mapped peripheral bridge.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cpu_addr/wdata/we/re  CPU MEM-stage access
//   cpu_rdata, cpu_stall  load data and MEM-stage hold
//   dev_addr, dev_wdata   shared device address/data bus
//   tmr_we, dgt_we        one-cycle device write strobes
//   tmr/sw/dgt_rdata      device read data
//   tmr_irq               timer interrupt level
//   hw_int[5:0]           CP0 hardware interrupt vector
// Macro IO_BRIDGE_ERR_EN adds the ERR/BADADDR status registers and the
// bus-error interrupt on hw_int[1].
module io_bridge
    import io_map_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [31:0] dev_addr,
    output logic [31:0] dev_wdata,
    output logic        tmr_we,
    output logic        dgt_we,
    input  logic [31:0] tmr_rdata,
    input  logic [31:0] sw_rdata,
    input  logic [31:0] dgt_rdata,
    input  logic        tmr_irq,
    output logic [5:0]  hw_int
);

    target_e     target;
    logic        writable;
    wbuf_t       wbuf_q, wbuf_d;
    logic        rd_only;
    logic        addr_hit;
    logic        load;
    logic        err_flag;
    logic [31:0] stat_rdata;

    io_addr_decode u_decode (
        .addr     (cpu_addr),
        .target   (target),
        .writable (writable)
    );

    // A simultaneous load/store request is a store.
    assign rd_only  = cpu_re && !cpu_we;
    assign addr_hit = (cpu_addr == wbuf_q.addr);
    assign load     = cpu_we && writable && (target == TGT_TMR || target == TGT_DGT);

    always_comb begin
        wbuf_d.valid  = load;
        wbuf_d.addr   = cpu_addr;
        wbuf_d.data   = cpu_wdata;
        wbuf_d.target = target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wbuf_q <= '0;
        end else begin
            wbuf_q <= wbuf_d;
        end
    end

    // Outputs are gated by reset so a store buffered just before reset
    // never reaches a device.
    assign dev_addr  = (wbuf_q.valid && !reset) ? wbuf_q.addr : cpu_addr;
    assign dev_wdata = (wbuf_q.valid && !reset) ? wbuf_q.data : cpu_wdata;
    assign tmr_we    = !reset && wbuf_q.valid && (wbuf_q.target == TGT_TMR);
    assign dgt_we    = !reset && wbuf_q.valid && (wbuf_q.target == TGT_DGT);
    // A load that misses the pending write waits one cycle for the drain.
    assign cpu_stall = !reset && wbuf_q.valid && rd_only && !addr_hit;

    always_comb begin
        if (wbuf_q.valid && rd_only && addr_hit) begin
            cpu_rdata = wbuf_q.data;
        end else begin
            case (target)
                TGT_TMR:  cpu_rdata = tmr_rdata;
                TGT_SW:   cpu_rdata = sw_rdata;
                TGT_DGT:  cpu_rdata = dgt_rdata;
                TGT_STAT: cpu_rdata = stat_rdata;
                default:  cpu_rdata = 32'h0;
            endcase
        end
    end

`ifdef IO_BRIDGE_ERR_EN
    logic [31:0] err_q, err_d;
    logic [31:0] badaddr_q, badaddr_d;
    logic        stat_clear;
    logic        bus_err;

    assign stat_clear = cpu_we && writable && (target == TGT_STAT);
    // Stalled loads repeat next cycle; count an unmapped load only once.
    assign bus_err    = (cpu_we && !writable) ||
                        (rd_only && target == TGT_NONE && !cpu_stall);

    always_comb begin
        err_d     = err_q;
        badaddr_d = badaddr_q;
        if (stat_clear) begin
            err_d     = '0;
            badaddr_d = '0;
        end
        // Applied after the clear so a coincident error survives it.
        if (bus_err) begin
            if (!err_d[0]) begin
                badaddr_d = cpu_addr;
            end
            err_d[0] = 1'b1;
            if (err_d[31:16] != 16'hffff) begin
                err_d[31:16] = err_d[31:16] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q     <= '0;
            badaddr_q <= '0;
        end else begin
            err_q     <= err_d;
            badaddr_q <= badaddr_d;
        end
    end

    assign stat_rdata = (cpu_addr == STAT_BADADDR) ? badaddr_q : err_q;
    assign err_flag   = err_q[0];
`else
    assign stat_rdata = 32'h0;
    assign err_flag   = 1'b0;
`endif

    assign hw_int = reset ? 6'b0 : {4'b0000, err_flag, tmr_irq};

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed self-checking bench for io_bridge.
// Build with +define+IO_BRIDGE_ERR_EN to exercise the status registers.
`timescale 1ns/1ps
module tb_io_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_we, cpu_re;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [31:0] dev_addr, dev_wdata;
    logic        tmr_we, dgt_we;
    logic [31:0] tmr_rdata, sw_rdata, dgt_rdata;
    logic        tmr_irq;
    logic [5:0]  hw_int;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    io_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .tmr_we    (tmr_we),
        .dgt_we    (dgt_we),
        .tmr_rdata (tmr_rdata),
        .sw_rdata  (sw_rdata),
        .dgt_rdata (dgt_rdata),
        .tmr_irq   (tmr_irq),
        .hw_int    (hw_int)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        cpu_re    = 1'b0;
        $display("store addr=%h data=%h", a, d);
    endtask

    task automatic load(input logic [31:0] a);
        cpu_addr = a;
        cpu_we   = 1'b0;
        cpu_re   = 1'b1;
        $display("load  addr=%h", a);
    endtask

    task automatic idle();
        cpu_addr = 32'h0000_1000;
        cpu_we   = 1'b0;
        cpu_re   = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cpu_wdata = 32'h0;
        tmr_rdata = 32'hdead_0000;
        sw_rdata  = 32'h0000_00a5;
        dgt_rdata = 32'h0000_d161;
        tmr_irq   = 1'b0;
        idle();
        tick();
        tick();
        #1;
        check("rst_tmr_we", {31'b0, tmr_we}, 32'h0);
        check("rst_dgt_we", {31'b0, dgt_we}, 32'h0);
        check("rst_stall", {31'b0, cpu_stall}, 32'h0);
        check("rst_hw_int", {26'b0, hw_int}, 32'h0);
        check("rst_dev_addr", dev_addr, 32'h0000_1000);
        reset = 1'b0;
        tick();

        // Display store: strobe one cycle later.
        store(32'h7f3c, 32'h8000_0005);
        tick();
        idle();
        #1;
        check("dgt_we", {31'b0, dgt_we}, 32'h1);
        check("dgt_tmr_we", {31'b0, tmr_we}, 32'h0);
        check("dgt_dev_addr", dev_addr, 32'h7f3c);
        check("dgt_dev_wdata", dev_wdata, 32'h8000_0005);
        tick();
        check("dgt_we_clear", {31'b0, dgt_we}, 32'h0);
        check("dev_addr_idle", dev_addr, 32'h0000_1000);

        // Store then load same address: forwarded.
        store(32'h7f00, 32'h12);
        tick();
        load(32'h7f00);
        #1;
        check("fwd_rdata", cpu_rdata, 32'h12);
        check("fwd_stall", {31'b0, cpu_stall}, 32'h0);
        check("fwd_tmr_we", {31'b0, tmr_we}, 32'h1);
        tick();
        check("tmr_read", cpu_rdata, 32'hdead_0000);

        // Store then load a different device: one-cycle stall.
        store(32'h7f38, 32'h77);
        tick();
        load(32'h7f2c);
        #1;
        check("stall_on", {31'b0, cpu_stall}, 32'h1);
        check("stall_dgt_we", {31'b0, dgt_we}, 32'h1);
        tick();
        check("stall_off", {31'b0, cpu_stall}, 32'h0);
        check("stall_rdata", cpu_rdata, 32'h0000_00a5);
        check("stall_dgt_done", {31'b0, dgt_we}, 32'h0);

        // Three back-to-back stores drain one per cycle.
        store(32'h7f00, 32'h1111_0001);
        tick();
        check("b2b1_tmr_we", {31'b0, tmr_we}, 32'h1);
        check("b2b1_addr", dev_addr, 32'h7f00);
        store(32'h7f38, 32'h2222_0002);
        #1;
        check("b2b_stall", {31'b0, cpu_stall}, 32'h0);
        tick();
        check("b2b2_dgt_we", {31'b0, dgt_we}, 32'h1);
        check("b2b2_tmr_we", {31'b0, tmr_we}, 32'h0);
        check("b2b2_addr", dev_addr, 32'h7f38);
        check("b2b2_data", dev_wdata, 32'h2222_0002);
        store(32'h7f3c, 32'h3333_0003);
        tick();
        idle();
        #1;
        check("b2b3_dgt_we", {31'b0, dgt_we}, 32'h1);
        check("b2b3_addr", dev_addr, 32'h7f3c);
        check("b2b3_data", dev_wdata, 32'h3333_0003);
        tick();
        check("b2b_done", {30'b0, tmr_we, dgt_we}, 32'h0);

        // Read decode: timer word, display, unmapped, misaligned.
        load(32'h7f08);
        #1;
        check("rd_tmr_hi", cpu_rdata, 32'hdead_0000);
        load(32'h7f3c);
        #1;
        check("rd_dgt", cpu_rdata, 32'h0000_d161);
        load(32'h7f10);
        #1;
        check("rd_unmapped", cpu_rdata, 32'h0);
        load(32'h7f01);
        #1;
        check("rd_misaligned", cpu_rdata, 32'h0);
        load(32'h7f40);
        #1;
`ifndef IO_BRIDGE_ERR_EN
        check("rd_stat_unmapped", cpu_rdata, 32'h0);
`endif
        idle();
        tick();

        // Switch store is dropped.
        store(32'h7f2c, 32'h5);
        tick();
        idle();
        #1;
        check("sw_store_dropped", {30'b0, tmr_we, dgt_we}, 32'h0);

        // Timer interrupt passthrough.
        tmr_irq = 1'b1;
        #1;
        check("irq_hw_int0", {31'b0, hw_int[0]}, 32'h1);
        tmr_irq = 1'b0;
        #1;
        check("irq_hw_int0_low", {31'b0, hw_int[0]}, 32'h0);

`ifdef IO_BRIDGE_ERR_EN
        // Clear earlier errors, then fault on a switch store.
        store(32'h7f40, 32'h0);
        tick();
        load(32'h7f40);
        #1;
        check("err_cleared", cpu_rdata, 32'h0);
        check("err_irq_clear", {26'b0, hw_int}, 32'h0);
        store(32'h7f2c, 32'h1);
        tick();
        load(32'h7f40);
        #1;
        check("err_val", cpu_rdata, 32'h0001_0001);
        check("err_irq", {31'b0, hw_int[1]}, 32'h1);
        load(32'h7f44);
        #1;
        check("badaddr", cpu_rdata, 32'h7f2c);
        store(32'h7f40, 32'h0);
        tick();
        load(32'h7f40);
        #1;
        check("err_clear2", cpu_rdata, 32'h0);
        check("err_irq_off", {31'b0, hw_int[1]}, 32'h0);
        idle();
        tick();
`else
        check("no_err_irq", {31'b0, hw_int[1]}, 32'h0);
`endif

        // Reset in the cycle after a store discards it.
        store(32'h7f00, 32'h99);
        tick();
        idle();
        reset   = 1'b1;
        tmr_irq = 1'b1;
        #1;
        check("rstw_tmr_we", {31'b0, tmr_we}, 32'h0);
        check("rstw_dgt_we", {31'b0, dgt_we}, 32'h0);
        check("rstw_dev_addr", dev_addr, 32'h0000_1000);
        check("rstw_hw_int", {26'b0, hw_int}, 32'h0);
        check("rstw_stall", {31'b0, cpu_stall}, 32'h0);
        tick();
        reset   = 1'b0;
        tmr_irq = 1'b0;
        #1;
        check("post_rst_strobes", {30'b0, tmr_we, dgt_we}, 32'h0);
        check("post_rst_dev_addr", dev_addr, 32'h0000_1000);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/io_bridge.md
# io_bridge

System bridge between the MIPS core's data-memory port and the memory-mapped peripherals (timer, DIP-switch reader, seven-segment display driver). It decodes CPU addresses in the 0x00007f00–0x00007f47 window, posts writes to devices through a one-entry registered write buffer, muxes device read data back to the core with read-after-write forwarding, and aggregates device interrupts plus a sticky bus-error flag into the core's hardware-interrupt vector.

## Interface
- No parameters; address map fixed by package constants.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_addr  in  32  byte address from MEM stage
- cpu_wdata  in  32  store data
- cpu_we  in  1  store request
- cpu_re  in  1  load request
- cpu_rdata  out  32  load data to MEM stage
- cpu_stall  out  1  hold MEM stage this cycle
- dev_addr  out  32  address to all devices
- dev_wdata  out  32  write data to all devices
- tmr_we  out  1  timer write strobe
- dgt_we  out  1  display write strobe
- tmr_rdata  in  32  timer read data
- sw_rdata  in  32  switch read data
- dgt_rdata  in  32  display read data
- tmr_irq  in  1  timer interrupt, level
- hw_int  out  6  interrupt vector to CP0

## Operation
- Map: timer 0x7f00–0x7f0b; switches 0x7f2c–0x7f33 (read-only); display 0x7f38, 0x7f3c; bridge status 0x7f40 (ERR), 0x7f44 (BADADDR). Word-aligned only; all else unmapped.
- Write buffer: one entry {valid, addr, data, target}. Cycle with cpu_we and mapped writable target → entry loads; next cycle dev_addr/dev_wdata drive entry, exactly one of tmr_we/dgt_we high for that cycle, entry clears unless a new write loads it (back-to-back writes drain one per cycle, no stall).
- dev_addr = entry.addr while entry valid, else cpu_addr.
- Read: cpu_rdata combinational from mux selected by cpu_addr. If entry valid and cpu_re:
  - cpu_addr == entry.addr → return entry.data (forward), no stall.
  - otherwise cpu_stall=1 for that cycle; read completes next cycle from device.
- Writes to switches: dropped, counted as bus error. cpu_we and cpu_re together: treated as write.
- hw_int[0]=tmr_irq; hw_int[1]=ERR[0]; hw_int[5:2]=0.
- Unmapped read returns 0.

## Timing
- Reset: entry invalid, cpu_stall=0, tmr_we=dgt_we=0, ERR=0, BADADDR=0, hw_int=0, dev_addr=cpu_addr.
- Device write latency: 1 cycle after CPU store.
- Read latency: 0 cycles (combinational), or 1 when stalled.
- Reset in the cycle after a store: buffered write discarded, no strobe issued.
- Error set and clear in same cycle: set wins.

## Configuration
- IO_BRIDGE_ERR_EN defined: ERR (bit0 sticky error flag, bits 31:16 saturating error count at 0xffff) and BADADDR (first faulting address since last clear) implemented; any write to 0x7f40 clears ERR and BADADDR; hw_int[1] driven.
- Undefined: no error logic; 0x7f40/0x7f44 unmapped; hw_int[1]=0; unmapped accesses silently ignored.

## Structure
- Package io_map_pkg: base/limit address constants per device, status register addresses, device-target enumeration (NONE, TMR, SW, DGT, STAT).
- Sub-module io_addr_decode: combinational address → target + writable flag; instantiated once.

## Test plan
- Store 0x80000005 to 0x7f3c → next cycle dgt_we=1, dev_addr=0x7f3c, dev_wdata=0x80000005; tmr_we=0.
- Store 0x12 to 0x7f00 then load 0x7f00 next cycle → forwarded cpu_rdata=0x12, cpu_stall=0.
- Store to 0x7f38 then load 0x7f2c (sw_rdata=0xa5) next cycle → cpu_stall=1 one cycle, then cpu_rdata=0xa5.
- Three back-to-back stores to 0x7f00, 0x7f38, 0x7f3c → three consecutive single-cycle strobes, no stall.
- With IO_BRIDGE_ERR_EN: store to 0x7f2c → ERR=0x00010001, BADADDR=0x7f2c, hw_int[1]=1; store to 0x7f40 → ERR=0, hw_int[1]=0.
- Store then reset next cycle → no tmr_we/dgt_we asserted; all outputs at reset values.
